shift_rows_pipe: RTL and testbench

Registered, parametrised ShiftRows / InvShiftRows stage for the Rijndael round datapath. It supports block widths of 128, 192 and 256 bits (Nb = 4, 6, 8 columns) and selects forward or inverse permutation per beat. A valid/ready handshake with a two-entry skid buffer lets it sit between SubBytes and MixColumns in both the encrypt and decrypt pipelines at full throughput under backpressure.

---
 rtl/shift_rows_pipe_if.sv | 25 ++
 rtl/shift_rows_pipe.sv | 84 ++++++++
 tb/tb_shift_rows_pipe.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/shift_rows_pipe_if.sv
// rtl/shift_rows_pipe_if.sv - valid/ready bundle for the ShiftRows stage
interface shift_rows_pipe_if #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
);
    logic                in_valid;
    logic                in_ready;
    logic                in_inv;
    logic [TAG_W-1:0]    in_tag;
    logic [32*NB-1:0]    in_state;
    logic                out_valid;
    logic                out_ready;
    logic [32*NB-1:0]    out_state;
    logic [TAG_W-1:0]    out_tag;

    modport master (
        output in_valid, in_inv, in_tag, in_state, out_ready,
        input  in_ready, out_valid, out_state, out_tag
    );

    modport slave (
        input  in_valid, in_inv, in_tag, in_state, out_ready,
        output in_ready, out_valid, out_state, out_tag
    );
endinterface

// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - registered ShiftRows/InvShiftRows stage with two-entry skid
module shift_rows_pipe #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_rows_pipe_if.slave  bus
);
    localparam int W = 32 * NB;

    generate
        if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("shift_rows_pipe: TAG_W must be at least 1");
        end
    endgenerate

    logic [W-1:0] fwd;
    logic [W-1:0] inv_p;
    logic [W-1:0] perm;

    // Pure byte re-wiring; the 256-bit variant skips offset 2 on rows 2 and 3.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int OFF = (NB == 8 && r >= 2) ? r + 1 : r;
            localparam int SF  = (c + OFF) % NB;
            localparam int SI  = (c - OFF + NB) % NB;
            assign fwd[W-1-32*c-8*r -: 8]   = bus.in_state[W-1-32*SF-8*r -: 8];
            assign inv_p[W-1-32*c-8*r -: 8] = bus.in_state[W-1-32*SI-8*r -: 8];
        end
    end

    assign perm = bus.in_inv ? inv_p : fwd;

    logic [W-1:0]     out_state_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_valid_q;
    logic [W-1:0]     skid_state_q;
    logic [TAG_W-1:0] skid_tag_q;
    logic             skid_valid_q;

    logic acc;
    logic pop;

    assign acc = bus.in_valid & ~skid_valid_q;
    assign pop = out_valid_q & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state_q  <= '0;
            out_tag_q    <= '0;
            out_valid_q  <= 1'b0;
            skid_state_q <= '0;
            skid_tag_q   <= '0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || pop) begin
            // Skid drains first so order is preserved; acc cannot occur while it is full.
            if (skid_valid_q) begin
                out_state_q  <= skid_state_q;
                out_tag_q    <= skid_tag_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (acc) begin
                out_state_q <= perm;
                out_tag_q   <= bus.in_tag;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (acc) begin
            skid_state_q <= perm;
            skid_tag_q   <= bus.in_tag;
            skid_valid_q <= 1'b1;
        end
    end

    assign bus.in_ready  = ~skid_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = out_state_q;
    assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb/tb_shift_rows_pipe.sv - directed-vector bench for shift_rows_pipe
module tb_shift_rows_pipe;
    logic clk;
    logic rst_n;

    shift_rows_pipe_if #(.NB(4), .TAG_W(8)) bus4 ();
    shift_rows_pipe_if #(.NB(8), .TAG_W(4)) bus8 ();

    shift_rows_pipe #(.NB(4), .TAG_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] VEC_A = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] VEC_B = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [127:0] st, input logic inv, input logic [7:0] tg);
        @(negedge clk);
        bus4.in_valid  = 1'b1;
        bus4.in_state  = st;
        bus4.in_inv    = inv;
        bus4.in_tag    = tg;
        bus4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
    endtask

    task automatic beat8(input logic [255:0] st, input logic inv);
        @(negedge clk);
        bus8.in_valid = 1'b1;
        bus8.in_state = st;
        bus8.in_inv   = inv;
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
    endtask

    initial begin
        logic [127:0] orig;
        logic [127:0] fwd_st;
        logic [127:0] hold_s;
        logic [7:0]   hold_t;
        logic [255:0] st8;
        logic         have_hold;
        logic         acc;
        logic         pop;
        int           i;
        int           exp_t;
        int           cnt;
        int           k;

        rst_n = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_inv = 1'b0; bus4.in_tag = '0;
        bus4.in_state = '0;   bus4.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_inv = 1'b0; bus8.in_tag = '0;
        bus8.in_state = '0;   bus8.out_ready = 1'b1;
        #1;
        check("rst_out_valid", bus4.out_valid, 0);
        check("rst_in_ready", bus4.in_ready, 1);
        check("rst_out_state", bus4.out_state, 0);
        check("rst_out_tag", bus4.out_tag, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 forward, then inverse, one-cycle latency
        beat(VEC_A, 1'b0, 8'd3);
        check("fips_fwd_valid", bus4.out_valid, 1);
        check("fips_fwd_state", bus4.out_state, VEC_B);
        check("fips_fwd_tag", bus4.out_tag, 3);
        beat(VEC_B, 1'b1, 8'd4);
        check("fips_inv_state", bus4.out_state, VEC_A);
        check("fips_inv_tag", bus4.out_tag, 4);

        for (int n = 0; n < 1000; n++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            beat(orig, 1'b0, 8'(n));
            fwd_st = bus4.out_state;
            beat(fwd_st, 1'b1, 8'(n));
            check("roundtrip", bus4.out_state, orig);
        end

        // NB=8 byte index check: byte at column c, row r holds 8c+r
        st8 = '0;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 4; r++)
                st8[255-32*c-8*r -: 8] = 8'(8*c + r);
        beat8(st8, 1'b0);
        check("nb8_fwd_col0", bus8.out_state[255:224], 32'h00091a23);
        check("nb8_fwd_col7", bus8.out_state[31:0], 32'h3801121b);
        beat8(st8, 1'b1);
        check("nb8_inv_col0", bus8.out_state[255:224], 32'h00392a23);
        check("nb8_inv_col7", bus8.out_state[31:0], 32'h3831221b);

        // Mode interleave at full rate: A fwd -> B, B inv -> A
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j > 0) begin
                check("ilv_valid", bus4.out_valid, 1);
                check("ilv_state", bus4.out_state, ((j - 1) % 2 == 0) ? VEC_B : VEC_A);
            end
            bus4.in_valid  = 1'b1;
            bus4.out_ready = 1'b1;
            bus4.in_inv    = (j % 2 == 1);
            bus4.in_state  = (j % 2 == 1) ? VEC_B : VEC_A;
            bus4.in_tag    = 8'(j);
        end
        @(negedge clk);
        bus4.in_valid = 1'b0;
        check("ilv_last", bus4.out_state, VEC_A);
        @(negedge clk);
        check("ilv_drain", bus4.out_valid, 0);

        // Backpressure stream, occupancy model predicts in_ready/out_valid
        i = 1; exp_t = 1; cnt = 0; k = 0; have_hold = 1'b0;
        hold_s = '0; hold_t = '0;
        while (exp_t <= 20 && k < 400) begin
            @(negedge clk);
            if (have_hold) begin
                check("stall_state", bus4.out_state, hold_s);
                check("stall_tag", bus4.out_tag, hold_t);
            end
            bus4.out_ready = (k >= 5 && k <= 9) ? 1'b0 : (k < 5) ? 1'b1 : 1'($urandom % 2);
            bus4.in_valid  = (i <= 20);
            bus4.in_inv    = 1'b0;
            bus4.in_tag    = 8'(i);
            bus4.in_state  = {16{8'(i)}};
            check("bp_in_ready", bus4.in_ready, (cnt < 2));
            check("bp_out_valid", bus4.out_valid, (cnt > 0));
            acc = (i <= 20) && (cnt < 2);
            pop = (cnt > 0) && bus4.out_ready;
            if (pop) begin
                check("bp_tag", bus4.out_tag, exp_t);
                check("bp_state", bus4.out_state, {16{8'(exp_t)}});
                exp_t++;
            end
            have_hold = (cnt > 0) && !bus4.out_ready;
            hold_s = bus4.out_state;
            hold_t = bus4.out_tag;
            cnt = cnt + int'(acc) - int'(pop);
            if (acc) i++;
            @(posedge clk);
            k++;
        end
        if (exp_t <= 20) check("bp_timeout", exp_t, 21);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset with output and skid both full
        bus4.out_ready = 1'b0;
        bus4.in_valid  = 1'b1;
        bus4.in_inv    = 1'b0;
        bus4.in_state  = VEC_A;
        bus4.in_tag    = 8'd5;
        @(posedge clk);
        @(negedge clk);
        bus4.in_state = VEC_B;
        bus4.in_tag   = 8'd6;
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        check("full_in_ready", bus4.in_ready, 0);
        check("full_out_valid", bus4.out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus4.out_valid, 0);
        check("mid_rst_in_ready", bus4.in_ready, 1);
        check("mid_rst_out_state", bus4.out_state, 0);
        check("mid_rst_out_tag", bus4.out_tag, 0);
        #1 rst_n = 1'b1;
        beat(VEC_A, 1'b0, 8'd7);
        check("post_rst_valid", bus4.out_valid, 1);
        check("post_rst_state", bus4.out_state, VEC_B);
        check("post_rst_tag", bus4.out_tag, 7);
        @(negedge clk);
        check("post_rst_drain", bus4.out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
